// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and a multi-cycle memory.
// The unit drives the request side. The memory returns data with a
// one-cycle mem_ack pulse.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit. It turns the core's single-cycle lw/sw intent into a
// req/ack transaction on a multi-cycle data memory. It stalls the core
// until the access completes, and it flags misaligned word accesses and
// memory timeouts.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Stall,
  output logic                  MisalignErr,
  output logic                  TimeoutErr,
  load_store_unit_if.master     bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // Last counter value of a REQ phase before it is aborted. The counter is 8 bits wide.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q;
  logic       access;
  logic       aligned;
  logic       timeout_hit;

  assign access      = MemRead | MemWrite;
  assign aligned     = (Addr[1:0] == 2'b00);
  assign timeout_hit = (cnt_q == TIMEOUT_LAST);

  // State register. A reset returns to IDLE at once, so mem_req drops without waiting for a clock.
  always_ff @(posedge CLK or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and the combinational outputs: Stall, MisalignErr and mem_req.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. A path
    // that leaves a signal unassigned would infer a latch.
    state_d     = state_q;
    Stall       = 1'b0;
    MisalignErr = 1'b0;
    bus.mem_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            Stall   = 1'b1;
            state_d = REQ;
          end else begin
            // The instruction proceeds unstalled. Control suppresses the register write.
            MisalignErr = 1'b1;
          end
        end
      end
      REQ: begin
        bus.mem_req = 1'b1;
        Stall       = 1'b1;
        if (bus.mem_ack || timeout_hit) state_d = DONE;
      end
      DONE: begin
        // The instruction commits here. It is still presented, but it is not re-issued.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latching, wait counter, load data and timeout flag.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      cnt_q         <= '0;
      ReadData      <= '0;
      TimeoutErr    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access && aligned) begin
            // MemWrite wins when both strobes are high.
            bus.mem_addr  <= Addr;
            bus.mem_wdata <= WriteData;
            bus.mem_we    <= MemWrite;
            cnt_q         <= '0;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 8'd1;
          if (bus.mem_ack) begin
            // An ack wins over a timeout that falls in the same cycle.
            if (!bus.mem_we) ReadData <= bus.mem_rdata;
          end else if (timeout_hit) begin
            TimeoutErr <= 1'b1;
            // A store never disturbs ReadData, even when it is aborted.
            if (!bus.mem_we) ReadData <= '0;
          end
        end
        DONE: begin
          TimeoutErr <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. Each transaction pushes its
// expected outcome into a scoreboard queue. The expected outcome is popped
// and compared when the DUT reaches DONE.
module tb_load_store_unit;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          reset;
  logic          MemRead, MemWrite;
  logic [AW-1:0] Addr;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] ReadData;
  logic          Stall, MisalignErr, TimeoutErr;

  load_store_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(255)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Addr        (Addr),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .Stall       (Stall),
    .MisalignErr (MisalignErr),
    .TimeoutErr  (TimeoutErr),
    .bus         (bus.master)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          terr;
    int            stalls;
    int            reqs;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] rd_model;
  int            checks = 0;
  int            errors = 0;

  // Drives one lw/sw starting in an IDLE cycle (entered just after a rising edge).
  // ack_on = k acks on the k-th REQ cycle; ack_on = 0 never acks.
  // Returns just after the edge that leaves DONE.
  task automatic run_access(input string name, input logic we, input logic re,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input int ack_on, input logic [DW-1:0] rdata);
    exp_t          e, got;
    int            stall_n = 0;
    int            req_n   = 0;
    bit            done    = 0;
    bit            bus_bad = 0;
    logic [AW-1:0] bad_addr = '0;
    logic [DW-1:0] bad_wdata = '0;
    logic          bad_we = 1'b0;

    MemRead = re; MemWrite = we; Addr = addr; WriteData = wdata; bus.mem_ack = 1'b0;
    e.rdata  = we ? rd_model : ((ack_on > 0) ? rdata : '0);
    e.terr   = (ack_on == 0);
    e.reqs   = (ack_on > 0) ? ack_on : 255;
    e.stalls = e.reqs + 1;
    if (!we) rd_model = e.rdata;
    sb.push_back(e);

    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      #1;
      if (Stall === 1'b1) stall_n++;
      if (bus.mem_req === 1'b1) begin
        req_n++;
        if (!bus_bad && (bus.mem_addr !== addr || bus.mem_we !== we || bus.mem_wdata !== wdata)) begin
          bus_bad = 1; bad_addr = bus.mem_addr; bad_we = bus.mem_we; bad_wdata = bus.mem_wdata;
        end
        bus.mem_ack   = (req_n == ack_on);
        bus.mem_rdata = rdata;
      end else begin
        bus.mem_ack = 1'b0;
        if (req_n > 0) begin
          done = 1;
          got  = sb.pop_front();
          checks++;
          if (ReadData !== got.rdata) begin
            errors++; $display("FAIL %s ReadData got %h want %h", name, ReadData, got.rdata);
          end
          checks++;
          if (TimeoutErr !== got.terr) begin
            errors++; $display("FAIL %s TimeoutErr got %b want %b", name, TimeoutErr, got.terr);
          end
          checks++;
          if (stall_n != got.stalls) begin
            errors++; $display("FAIL %s stall_cycles got %0d want %0d", name, stall_n, got.stalls);
          end
          checks++;
          if (req_n != got.reqs) begin
            errors++; $display("FAIL %s req_cycles got %0d want %0d", name, req_n, got.reqs);
          end
          checks++;
          if (bus_bad) begin
            errors++;
            $display("FAIL %s bus_stable got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                     name, bad_addr, bad_we, bad_wdata, addr, we, wdata);
          end
          checks++;
          if (Stall !== 1'b0) begin
            errors++; $display("FAIL %s stall_in_done got %b want 0", name, Stall);
          end
        end
      end
      @(posedge CLK);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s completion got none want DONE within 400 cycles", name);
      void'(sb.pop_front());
    end
    #1;
  endtask

  // Non-memory instruction: no stall, no bus activity, error flags clear.
  task automatic idle_check(input string name);
    MemRead = 1'b0; MemWrite = 1'b0; bus.mem_ack = 1'b0;
    #1;
    checks++;
    if (Stall !== 1'b0 || bus.mem_req !== 1'b0 || TimeoutErr !== 1'b0) begin
      errors++;
      $display("FAIL %s idle got stall=%b req=%b terr=%b want 0 0 0", name, Stall, bus.mem_req, TimeoutErr);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; rd_model = '0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (ReadData !== '0 || Stall !== 1'b0 || MisalignErr !== 1'b0 || TimeoutErr !== 1'b0 ||
        bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_state got rd=%h st=%b me=%b te=%b req=%b we=%b a=%h wd=%h want all 0",
               ReadData, Stall, MisalignErr, TimeoutErr, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge CLK); reset = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_read_zero_wait();
    run_access("read_zero_wait", 1'b0, 1'b1, 32'h100, 32'h0, 1, 32'hCAFEF00D);
    idle_check("read_zero_wait");
  endtask

  task automatic test_write_waits();
    run_access("write_3_waits", 1'b1, 1'b0, 32'h204, 32'h12345678, 4, 32'hDEADDEAD);
    idle_check("write_3_waits");
  endtask

  task automatic test_misaligned();
    MemRead = 1'b1; MemWrite = 1'b0; Addr = 32'h102; bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (MisalignErr !== 1'b1 || Stall !== 1'b0 || bus.mem_req !== 1'b0 || ReadData !== rd_model) begin
        errors++;
        $display("FAIL misaligned cyc%0d got me=%b st=%b req=%b rd=%h want 1 0 0 %h",
                 i, MisalignErr, Stall, bus.mem_req, ReadData, rd_model);
      end
      @(posedge CLK);
    end
    #1;
    idle_check("misaligned");
  endtask

  task automatic test_priority();
    run_access("priority_rw", 1'b1, 1'b1, 32'h3F0, 32'hA5A5_0F0F, 2, 32'h1111_2222);
    idle_check("priority_rw");
  endtask

  task automatic test_spurious_ack();
    MemRead = 1'b0; MemWrite = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
    @(posedge CLK); #1;
    bus.mem_ack = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || Stall !== 1'b0 || ReadData !== rd_model) begin
      errors++;
      $display("FAIL spurious_ack got req=%b st=%b rd=%h want 0 0 %h", bus.mem_req, Stall, ReadData, rd_model);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    run_access("b2b_lw0", 1'b0, 1'b1, 32'h40, 32'h0, 1, 32'h0BAD_F00D);
    run_access("b2b_lw1", 1'b0, 1'b1, 32'h44, 32'h0, 2, 32'h7654_3210);
    idle_check("b2b");
  endtask

  task automatic test_timeout();
    run_access("timeout", 1'b0, 1'b1, 32'h500, 32'h0, 0, 32'h0);
    idle_check("timeout");
    run_access("ack_on_255", 1'b0, 1'b1, 32'h504, 32'h0, 255, 32'hFEED_BEEF);
    idle_check("ack_on_255");
  endtask

  task automatic test_reset_mid_op();
    run_access("pre_reset_lw", 1'b0, 1'b1, 32'h80, 32'h0, 1, 32'h5A5A_5A5A);
    idle_check("pre_reset_lw");
    MemRead = 1'b1; MemWrite = 1'b0; Addr = 32'h300; bus.mem_ack = 1'b0;
    @(posedge CLK); @(posedge CLK); #2;
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL reset_mid_op req_before got %b want 1", bus.mem_req);
    end
    reset = 1'b0; MemRead = 1'b0;
    rd_model = '0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || Stall !== 1'b0 || ReadData !== '0) begin
      errors++;
      $display("FAIL reset_mid_op async got req=%b st=%b rd=%h want 0 0 0", bus.mem_req, Stall, ReadData);
    end
    @(negedge CLK); reset = 1'b1;
    @(posedge CLK); #1;
    idle_check("after_reset");
    run_access("fresh_after_reset", 1'b0, 1'b1, 32'h308, 32'h0, 1, 32'h0102_0304);
    idle_check("fresh_after_reset");
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_misaligned();
    test_priority();
    test_spurious_ack();
    test_back_to_back();
    test_timeout();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish before 1ms");
    $fatal(1, "watchdog");
  end

endmodule
